// File: rtl/svi_mem_arbiter.sv
// ----------------------------------------------------------------------------
// svi_mem_arbiter
//
// Purpose: shares one byte-wide SDRAM port between four requesters:
//   download (dl)  - single-cycle write strobes, held in a one-entry buffer
//   cleanup  (clr) - level request, always writes 8'h00
//   CPU      (cpu) - level request, read or write
//   cassette (cas) - level request, read-only, eligible only while cas_win=1
// Fixed priority dl > clr > cpu > cas. Each access walks IDLE -> ISSUE ->
// WAIT -> ACK. A watchdog aborts a WAIT that never sees sd_ready.
//
// Ports:
//   clk_sys, reset             clock / synchronous active-high reset
//   dl_wr/dl_addr/dl_data      download write strobe, dl_ack completion
//   clr_req/clr_addr           cleanup request, clr_ack completion
//   cpu_req/cpu_we/cpu_addr/   CPU request, cpu_dout read data,
//   cpu_din                    cpu_ack completion
//   cas_req/cas_addr/cas_win   cassette request, cas_dout read data, cas_ack
//   sd_rd/sd_we/sd_addr/sd_din SDRAM command (one-cycle strobe, held address)
//   sd_dout/sd_ready           SDRAM read data and completion pulse
//   busy, err                  not-idle indicator, sticky error flag
//
// Optional build macro: SVI_ARB_RR_EN -- when defined, cpu and cas alternate
// priority whenever both are eligible in the same IDLE cycle.
// ----------------------------------------------------------------------------
module svi_mem_arbiter #(
   parameter int ADDR_W      = 23,
   parameter int WDOG_CYCLES = 64
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              dl_wr,
   input  logic [ADDR_W-1:0] dl_addr,
   input  logic [7:0]        dl_data,
   output logic              dl_ack,
   input  logic              clr_req,
   input  logic [ADDR_W-1:0] clr_addr,
   output logic              clr_ack,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [7:0]        cpu_din,
   output logic [7:0]        cpu_dout,
   output logic              cpu_ack,
   input  logic              cas_req,
   input  logic [ADDR_W-1:0] cas_addr,
   input  logic              cas_win,
   output logic [7:0]        cas_dout,
   output logic              cas_ack,
   output logic              sd_rd,
   output logic              sd_we,
   output logic [ADDR_W-1:0] sd_addr,
   output logic [7:0]        sd_din,
   input  logic [7:0]        sd_dout,
   input  logic              sd_ready,
   output logic              busy,
   output logic              err
);

   // Counter holds 0..WDOG_CYCLES-1 and is compared, never wrapped.
   localparam int               CNT_W     = $clog2(WDOG_CYCLES + 1);
   localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WDOG_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;
   typedef enum logic [1:0] {GNT_DL, GNT_CLR, GNT_CPU, GNT_CAS} gnt_t;

   state_t            r_state;
   gnt_t              r_gnt;
   logic              r_we;
   logic [CNT_W-1:0]  r_wdog;
   logic              r_dl_pend;
   logic [ADDR_W-1:0] r_dl_addr;
   logic [7:0]        r_dl_data;
   logic              r_clr_arm, r_cpu_arm, r_cas_arm;
   logic              r_sd_rd, r_sd_we;
   logic [ADDR_W-1:0] r_sd_addr;
   logic [7:0]        r_sd_din, r_cpu_dout, r_cas_dout;
   logic              r_dl_ack, r_clr_ack, r_cpu_ack, r_cas_ack;
   logic              r_busy, r_err;

   logic              w_clr_elig, w_cpu_elig, w_cas_elig, w_cas_wins;
   logic              w_any, w_grant, w_dl_grant, w_dl_drop;
   gnt_t              w_sel;
   logic [ADDR_W-1:0] w_sel_addr;
   logic [7:0]        w_sel_din;
   logic              w_sel_we;
   logic              w_wait_done;
   logic [7:0]        w_rd_data;

   assign w_clr_elig = clr_req && r_clr_arm;
   assign w_cpu_elig = cpu_req && r_cpu_arm;
   assign w_cas_elig = cas_req && r_cas_arm && cas_win;

`ifdef SVI_ARB_RR_EN
   // Set after a cpu grant, cleared after a cas grant: the last winner loses a tie.
   logic r_rr_cas_first;
   always_ff @(posedge clk_sys) begin
      if (reset)
         r_rr_cas_first <= 1'b0;
      else if (w_grant && w_sel == GNT_CPU)
         r_rr_cas_first <= 1'b1;
      else if (w_grant && w_sel == GNT_CAS)
         r_rr_cas_first <= 1'b0;
   end
   assign w_cas_wins = w_cas_elig && (!w_cpu_elig || r_rr_cas_first);
`else
   assign w_cas_wins = w_cas_elig && !w_cpu_elig;
`endif

   always_comb begin
      w_any      = 1'b1;
      w_sel      = GNT_DL;
      w_sel_addr = r_dl_addr;
      w_sel_din  = r_dl_data;
      w_sel_we   = 1'b1;
      if (!r_dl_pend) begin
         if (w_clr_elig) begin
            w_sel      = GNT_CLR;
            w_sel_addr = clr_addr;
            w_sel_din  = 8'h00;
         end else if (w_cpu_elig && !w_cas_wins) begin
            w_sel      = GNT_CPU;
            w_sel_addr = cpu_addr;
            w_sel_din  = cpu_din;
            w_sel_we   = cpu_we;
         end else if (w_cas_wins) begin
            w_sel      = GNT_CAS;
            w_sel_addr = cas_addr;
            w_sel_din  = 8'h00;
            w_sel_we   = 1'b0;
         end else begin
            w_any = 1'b0;
         end
      end
   end

   assign w_grant    = (r_state == IDLE) && w_any;
   assign w_dl_grant = w_grant && (w_sel == GNT_DL);
   // Overflow: buffer full and not being emptied by a grant this same edge.
   assign w_dl_drop  = dl_wr && r_dl_pend && !w_dl_grant;

   // A missing sd_ready at the last watchdog cycle completes the read with 8'hFF.
   assign w_wait_done = sd_ready || (r_wdog == WDOG_LAST);
   assign w_rd_data   = sd_ready ? sd_dout : 8'hFF;

   // Download buffer: a strobe coinciding with the grant refills the freed slot.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_dl_pend <= 1'b0;
         r_dl_addr <= '0;
         r_dl_data <= 8'h00;
      end else if (dl_wr && !w_dl_drop) begin
         r_dl_pend <= 1'b1;
         r_dl_addr <= dl_addr;
         r_dl_data <= dl_data;
      end else if (w_dl_grant) begin
         r_dl_pend <= 1'b0;
      end
   end

   // Level requesters disarm on grant and re-arm only on a low req sampled
   // while they are not the access in flight (i.e. after their ack).
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_clr_arm <= 1'b1;
         r_cpu_arm <= 1'b1;
         r_cas_arm <= 1'b1;
      end else begin
         if (w_grant && w_sel == GNT_CLR)
            r_clr_arm <= 1'b0;
         else if (!clr_req && !(r_state != IDLE && r_gnt == GNT_CLR))
            r_clr_arm <= 1'b1;
         if (w_grant && w_sel == GNT_CPU)
            r_cpu_arm <= 1'b0;
         else if (!cpu_req && !(r_state != IDLE && r_gnt == GNT_CPU))
            r_cpu_arm <= 1'b1;
         if (w_grant && w_sel == GNT_CAS)
            r_cas_arm <= 1'b0;
         else if (!cas_req && !(r_state != IDLE && r_gnt == GNT_CAS))
            r_cas_arm <= 1'b1;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         r_state    <= IDLE;
         r_gnt      <= GNT_DL;
         r_we       <= 1'b0;
         r_wdog     <= '0;
         r_sd_rd    <= 1'b0;
         r_sd_we    <= 1'b0;
         r_sd_addr  <= '0;
         r_sd_din   <= 8'h00;
         r_cpu_dout <= 8'h00;
         r_cas_dout <= 8'h00;
         r_dl_ack   <= 1'b0;
         r_clr_ack  <= 1'b0;
         r_cpu_ack  <= 1'b0;
         r_cas_ack  <= 1'b0;
         r_busy     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         if (w_dl_drop)
            r_err <= 1'b1;
         case (r_state)
            IDLE: begin
               if (w_grant) begin
                  r_gnt     <= w_sel;
                  r_we      <= w_sel_we;
                  r_sd_addr <= w_sel_addr;
                  r_sd_din  <= w_sel_din;
                  r_sd_rd   <= !w_sel_we;
                  r_sd_we   <= w_sel_we;
                  r_busy    <= 1'b1;
                  r_state   <= ISSUE;
               end
            end
            ISSUE: begin
               r_sd_rd <= 1'b0;
               r_sd_we <= 1'b0;
               r_wdog  <= '0;
               r_state <= WAIT;
            end
            WAIT: begin
               if (w_wait_done) begin
                  if (!r_we && r_gnt == GNT_CPU)
                     r_cpu_dout <= w_rd_data;
                  if (!r_we && r_gnt == GNT_CAS)
                     r_cas_dout <= w_rd_data;
                  if (!sd_ready)
                     r_err <= 1'b1;
                  r_dl_ack  <= (r_gnt == GNT_DL);
                  r_clr_ack <= (r_gnt == GNT_CLR);
                  r_cpu_ack <= (r_gnt == GNT_CPU);
                  r_cas_ack <= (r_gnt == GNT_CAS);
                  r_state   <= ACK;
               end else begin
                  r_wdog <= r_wdog + 1'b1;
               end
            end
            ACK: begin
               r_dl_ack  <= 1'b0;
               r_clr_ack <= 1'b0;
               r_cpu_ack <= 1'b0;
               r_cas_ack <= 1'b0;
               r_busy    <= 1'b0;
               r_state   <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign sd_rd    = r_sd_rd;
   assign sd_we    = r_sd_we;
   assign sd_addr  = r_sd_addr;
   assign sd_din   = r_sd_din;
   assign cpu_dout = r_cpu_dout;
   assign cas_dout = r_cas_dout;
   assign dl_ack   = r_dl_ack;
   assign clr_ack  = r_clr_ack;
   assign cpu_ack  = r_cpu_ack;
   assign cas_ack  = r_cas_ack;
   assign busy     = r_busy;
   assign err      = r_err;

endmodule

// File: doc/svi_mem_arbiter.md
SVI_MEM_ARBITER -- requirements
Module: svi_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 23, meaning SDRAM byte-address width.
REQ-002 SHALL have parameter WDOG_CYCLES, default 64, meaning maximum WAIT cycles before an access is aborted.
REQ-003 SHALL have the following port: clk_sys  in  1  system clock; all logic on its rising edge.
REQ-004 SHALL have the following port: reset  in  1  reset; synchronous and active-high.
REQ-005 SHALL have the download ports: dl_wr in 1 (single-cycle write strobe), dl_addr in ADDR_W, dl_data in 8, dl_ack out 1.
REQ-006 SHALL have the cleanup ports: clr_req in 1 (level), clr_addr in ADDR_W, clr_ack out 1; cleanup write data is fixed at 8'h00.
REQ-007 SHALL have the CPU ports: cpu_req in 1 (level), cpu_we in 1, cpu_addr in ADDR_W, cpu_din in 8, cpu_dout out 8, cpu_ack out 1.
REQ-008 SHALL have the cassette ports: cas_req in 1 (level, read-only), cas_addr in ADDR_W, cas_win in 1 (refresh window), cas_dout out 8, cas_ack out 1.
REQ-009 SHALL have the SDRAM-side ports: sd_rd out 1, sd_we out 1, sd_addr out ADDR_W, sd_din out 8, sd_dout in 8, sd_ready in 1 (single-cycle completion pulse).
REQ-010 SHALL have the status ports: busy out 1 (high in every state except IDLE) and err out 1 (sticky error flag).

Function
REQ-011 SHALL use FSM states IDLE, ISSUE, WAIT and ACK.
REQ-012 IDLE: on each edge, SHALL grant the highest-priority eligible requester, latch its address, data and direction, and go to ISSUE.
- Priority order: dl > clr > cpu > cas.
- cas is eligible only when cas_win=1 at that edge.
REQ-013 ISSUE: SHALL assert sd_rd or sd_we for exactly one cycle with the latched sd_addr/sd_din, then go to WAIT.
REQ-014 WAIT: when sd_ready=1 is sampled, SHALL capture sd_dout into the granted requester's read register (cpu_dout or cas_dout) and go to ACK.
- Write accesses leave both read registers unchanged.
REQ-015 ACK: SHALL pulse the granted requester's *_ack for exactly one cycle, then return to IDLE.
REQ-016 Minimum latency, with sd_ready arriving in the first WAIT cycle:
- request sampled at edge 0;
- sd_rd/sd_we high in cycle 1;
- ack high in cycle 3.
REQ-017 sd_addr and sd_din SHALL stay stable from ISSUE through WAIT.
REQ-018 A level requester (clr, cpu, cas) SHALL re-arm only after its req has been sampled low for at least one cycle after its ack, so a held req never causes a duplicate access.
REQ-019 dl_wr SHALL be captured into a one-entry pending buffer in any state.
- The buffer is cleared when dl is granted.
- A dl_wr arriving while the buffer is already full SHALL be dropped and SHALL set err.
- A dl_wr arriving in the same cycle as the grant of the pending entry SHALL be accepted into the freed buffer.
REQ-020 If sd_ready is not seen within WDOG_CYCLES cycles of WAIT, the FSM SHALL:
- abort to ACK;
- load 8'hFF into the read register if the access was a read;
- set err.
REQ-021 sd_ready sampled outside WAIT SHALL be ignored.
REQ-022 The WAIT counter SHALL be wide enough to hold WDOG_CYCLES and SHALL not wrap.

Reset
REQ-023 While reset=1, the block SHALL:
- hold the FSM in IDLE;
- drive sd_rd, sd_we, all *_ack, busy and err to 0;
- set sd_addr and sd_din to 0;
- set cpu_dout and cas_dout to 8'h00;
- empty the dl buffer;
- re-arm all level requesters.
REQ-024 Reset asserted mid-access SHALL abandon the access with no ack, and sd_ready arriving afterwards SHALL be ignored.

Configuration
REQ-025 With macro SVI_ARB_RR_EN defined, cpu and cas SHALL alternate priority when both are eligible in the same IDLE cycle; the one granted last loses.
- The alternation bit resets to "cpu first".
REQ-026 With SVI_ARB_RR_EN undefined, cpu SHALL always beat cas; dl and clr priority is unaffected either way.

Verification
REQ-027 CPU read at cpu_addr=0x01234, with sd_ready in the first WAIT cycle and sd_dout=0x5A -> sd_rd pulses once in cycle 1, cpu_ack high in cycle 3, cpu_dout=0x5A.
REQ-028 dl_wr pulses at cycles 0 and 2 while the FSM is busy, with addresses 0x10 and 0x11 -> two sd_we pulses in order with matching addresses and err=0; a third pulse while the buffer is full -> err=1.
REQ-029 cpu_req and cas_req both high with cas_win=1 for 4 accesses -> SVI_ARB_RR_EN defined: grant order cpu,cas,cpu,cas; undefined: cpu,cpu,cpu,cpu.
REQ-030 cas_req high with cas_win=0 for 10 cycles, then cas_win=1 -> no sd_rd while cas_win=0; exactly one sd_rd once cas_win is high.
REQ-031 CPU read with sd_ready withheld -> cpu_ack WDOG_CYCLES+1 cycles after ISSUE, cpu_dout=0xFF, err=1.
REQ-032 reset asserted in WAIT, then sd_ready pulsed -> no ack and all outputs 0; the next request completes normally.
